ldm_line_rx: RTL and testbench

//  Panel-side receiver for the LDM line-scan interface driven by top.

---
 rtl/ldm_line_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_ldm_line_rx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_line_rx.sv
// -----------------------------------------------------------------------------
// ldm_line_rx
//
// Panel-side receiver for the LDM line-scan interface. The transmitter sends a
// frame as LINES consecutive lines, each marked by a rising edge on LDM_CLK.
// This block samples the LDM_* inputs in the system clock domain. It checks that
// the lines arrive in order 0..LINES-1 and collects them in a shadow frame. When
// a frame completes, the shadow frame is published on FRAME_DATA_256 together
// with a one-cycle FRAME_VALID strobe. Protocol violations (a skipped or
// repeated line, or a stall longer than TIMEOUT cycles) abort the frame and
// produce a one-cycle FRAME_ERR strobe.
//
// Ports
//   clk             in   system clock, rising edge
//   rstn            in   asynchronous active-low reset
//   LDM_CLK         in   line strobe; a rising edge marks a new line
//   LDM_ADDR_EN     in   qualifies LDM_ADDR / LDM_LINE_DATA for this strobe
//   LDM_ADDR        in   line address
//   LDM_LINE_DATA   in   line pixels, bit 0 = leftmost pixel
//   FRAME_DATA_256  out  last complete frame, line 0 leftmost
//   FRAME_VALID     out  1-cycle pulse, new frame on FRAME_DATA_256
//   FRAME_ERR       out  1-cycle pulse, partial frame discarded
//   FRAME_CNT       out  number of completed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module ldm_line_rx #(
  parameter int LINES   = 16,
  parameter int LINE_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    LDM_CLK,
  input  logic                    LDM_ADDR_EN,
  input  logic [ADDR_W-1:0]       LDM_ADDR,
  input  logic [0:LINE_W-1]       LDM_LINE_DATA,
  output logic [0:LINES*LINE_W-1] FRAME_DATA_256,
  output logic                    FRAME_VALID,
  output logic                    FRAME_ERR,
  output logic [7:0]              FRAME_CNT
);

  localparam int                FRAME_W   = LINES * LINE_W;
  localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  // Input stage registers
  logic              r1_clk_q;
  logic              r2_clk_q;
  logic              r1_en_q;
  logic [ADDR_W-1:0] r1_addr_q;
  logic [LINE_W-1:0] r1_data_q;

  // Control state
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  // Frame storage and outputs
  logic [FRAME_W-1:0] shadow_q;
  logic [FRAME_W-1:0] frame_q;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;

  // Decoded strobe information
  logic              strobe;
  logic              lineEn;
  logic              addrHit;
  logic              addrZero;
  logic              shadowWe;
  logic              frameLoad;
  logic [ADDR_W-1:0] wrSlot;

  // Every LDM_* input goes through exactly one register stage, so the
  // address, data and enable seen together with the strobe all come from the
  // same sampling edge as the first high sample of LDM_CLK.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_clk_q  <= 1'b0;
      r2_clk_q  <= 1'b0;
      r1_en_q   <= 1'b0;
      r1_addr_q <= '0;
      r1_data_q <= '0;
    end else begin
      r1_clk_q  <= LDM_CLK;
      r2_clk_q  <= r1_clk_q;
      r1_en_q   <= LDM_ADDR_EN;
      r1_addr_q <= LDM_ADDR;
      r1_data_q <= LDM_LINE_DATA;
    end
  end

  assign strobe   = r1_clk_q & ~r2_clk_q;
  assign lineEn   = strobe & r1_en_q;
  assign addrHit  = (r1_addr_q == exp_q);
  assign addrZero = (r1_addr_q == '0);

  // Each write goes to the slot named by the sampled address. That address is
  // either the expected line or line 0 on a (re)start. Line 0 sits in the
  // most significant slot so that it ends up leftmost on FRAME_DATA_256.
  assign wrSlot = LAST_LINE - r1_addr_q;

  // Next-state logic.
  // DONE lasts one cycle. It applies the same strobe rules as IDLE, so a
  // line-0 strobe arriving right behind a finished frame starts the next one.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    tcnt_d    = tcnt_q;
    shadowWe  = 1'b0;
    frameLoad = 1'b0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          frameLoad = 1'b1;
          valid_d   = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
        state_d = IDLE;
        exp_d   = '0;
        tcnt_d  = '0;
        // Lines other than 0 are silently dropped until a frame starts.
        if (lineEn && addrZero) begin
          shadowWe = 1'b1;
          state_d  = RECV;
          exp_d    = ADDR_W'(1);
        end
      end

      RECV: begin
        if (lineEn && addrHit) begin
          shadowWe = 1'b1;
          tcnt_d   = '0;
          if (exp_q == LAST_LINE) begin
            state_d = DONE;
            exp_d   = '0;
          end else begin
            exp_d = exp_q + ADDR_W'(1);
          end
        end else if (lineEn) begin
          // Out-of-order line. A line 0 is taken as the first line of a
          // fresh frame; any other address drops back to waiting for one.
          err_d  = 1'b1;
          tcnt_d = '0;
          if (addrZero) begin
            shadowWe = 1'b1;
            exp_d    = ADDR_W'(1);
          end else begin
            state_d = IDLE;
            exp_d   = '0;
          end
        end else if (tcnt_q == TCNT_MAX) begin
          // This is the TIMEOUT-th consecutive cycle without an accepted line.
          // Strobes with the enable low do not reset the count.
          err_d   = 1'b1;
          state_d = IDLE;
          exp_d   = '0;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        exp_d   = '0;
        tcnt_d  = '0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      exp_q   <= '0;
      tcnt_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      tcnt_q  <= tcnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The shadow frame collects lines. The published frame changes only when
  // a frame completes, so errors never disturb what the panel sees.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q <= '0;
      frame_q  <= '0;
    end else begin
      if (shadowWe) begin
        shadow_q[int'(wrSlot)*LINE_W +: LINE_W] <= r1_data_q;
      end
      if (frameLoad) begin
        frame_q <= shadow_q;
      end
    end
  end

  assign FRAME_DATA_256 = frame_q;
  assign FRAME_VALID    = valid_q;
  assign FRAME_ERR      = err_q;
  assign FRAME_CNT      = cnt_q;

endmodule

// File: tb/tb_ldm_line_rx.sv
// -----------------------------------------------------------------------------
// tb_ldm_line_rx
//
// Drives LDM line traffic into ldm_line_rx and compares its outputs every cycle
// against a line-level reference model. The model tracks the next expected line
// index, the lines collected so far, and the idle time since the last accepted
// line. It predicts FRAME_ERR one cycle after the sampling edge of the line
// that caused it, and FRAME_VALID plus the new frame two cycles after the
// sampling edge of the last line. A few hand-computed literal expectations pin
// the model itself.
// -----------------------------------------------------------------------------
module tb_ldm_line_rx;

  localparam int LINES   = 16;
  localparam int LINE_W  = 16;
  localparam int TIMEOUT = 64;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    ldmClk = 1'b0;
  logic                    ldmEn = 1'b0;
  logic [3:0]              ldmAddr = '0;
  logic [0:LINE_W-1]       ldmData = '0;
  logic [0:LINES*LINE_W-1] frameData;
  logic                    frameValid;
  logic                    frameErr;
  logic [7:0]              frameCnt;

  ldm_line_rx #(
    .LINES  (LINES),
    .LINE_W (LINE_W),
    .ADDR_W (4),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .LDM_CLK       (ldmClk),
    .LDM_ADDR_EN   (ldmEn),
    .LDM_ADDR      (ldmAddr),
    .LDM_LINE_DATA (ldmData),
    .FRAME_DATA_256(frameData),
    .FRAME_VALID   (frameValid),
    .FRAME_ERR     (frameErr),
    .FRAME_CNT     (frameCnt)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int nChecks = 0;
  int nPass = 0;
  int validSeen = 0;
  int errSeen = 0;

  // Reference model state
  logic [15:0] mLine[LINES];
  logic [15:0] mFrame[LINES];
  logic [15:0] pendFrame[LINES];
  bit          mInFrame;
  int          mExp;
  int          mIdle;
  int          mCnt;
  bit          expValid;
  bit          expErr;
  bit          pendValid;
  // Last two samples the DUT took: prevClk from the older one, cur* from the newer
  bit          prevClk;
  bit          curClk;
  bit          curEn;
  logic [3:0]  curAddr;
  logic [15:0] curData;

  logic [15:0] stim[LINES];

  task automatic cmp(input string name, input logic [255:0] got, input logic [255:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("[TB] FAIL %s: got %h, want %h", name, got, want);
  endtask

  task automatic modelReset();
    for (int k = 0; k < LINES; k++) begin
      mLine[k] = '0;
      mFrame[k] = '0;
      pendFrame[k] = '0;
    end
    mInFrame = 0; mExp = 0; mIdle = 0; mCnt = 0;
    expValid = 0; expErr = 0; pendValid = 0;
    prevClk = 0; curClk = 0; curEn = 0; curAddr = '0; curData = '0;
  endtask

  // Process the newest DUT sample and move the expected outputs one cycle on.
  task automatic modelStep();
    bit edgeSeen;
    bit err;
    bit done;
    err = 0;
    done = 0;
    expValid = pendValid;
    if (pendValid) begin
      mFrame = pendFrame;
      mCnt = (mCnt + 1) % 256;
    end
    edgeSeen = curClk && !prevClk;
    if (!mInFrame) begin
      if (edgeSeen && curEn && curAddr == 4'd0) begin
        mLine[0] = curData;
        mInFrame = 1;
        mExp = 1;
        mIdle = 0;
      end
    end else if (edgeSeen && curEn) begin
      mIdle = 0;
      if (int'(curAddr) == mExp) begin
        mLine[mExp] = curData;
        if (mExp == LINES - 1) begin
          done = 1;
          mInFrame = 0;
          pendFrame = mLine;
        end else begin
          mExp++;
        end
      end else begin
        err = 1;
        if (curAddr == 4'd0) begin
          mLine[0] = curData;
          mExp = 1;
        end else begin
          mInFrame = 0;
        end
      end
    end else begin
      mIdle++;
      if (mIdle == TIMEOUT) begin
        err = 1;
        mInFrame = 0;
      end
    end
    expErr = err;
    pendValid = done;
  endtask

  task automatic checkOutput();
    logic [0:255] ev;
    for (int k = 0; k < LINES; k++) ev[k*16 +: 16] = mFrame[k];
    cmp("frame_valid", frameValid, expValid);
    cmp("frame_err", frameErr, expErr);
    cmp("frame_cnt", frameCnt, mCnt[7:0]);
    cmp("frame_data", frameData, ev);
    if (frameValid === 1'b1) validSeen++;
    if (frameErr === 1'b1) errSeen++;
  endtask

  // One clock of stimulus: check the current outputs, advance the model,
  // then drive the next input sample.
  task automatic applyStimulus(input logic c, input logic e, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    checkOutput();
    modelStep();
    ldmClk = c;
    ldmEn = e;
    ldmAddr = a;
    ldmData = d;
    prevClk = curClk;
    curClk = c;
    curEn = e;
    curAddr = a;
    curData = d;
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    ldmClk = 1'b0;
    ldmEn = 1'b0;
    ldmAddr = '0;
    ldmData = '0;
    modelReset();
    repeat (n) begin
      @(negedge clk);
      checkOutput();
    end
    rstn = 1'b1;
  endtask

  // Only the first high cycle carries meaningful data. The remaining high
  // and low cycles carry random don't-care values.
  task automatic sendLine(input logic [3:0] a, input logic [15:0] d, input logic e, input int hi, input int lo);
    applyStimulus(1'b1, e, a, d);
    for (int i = 1; i < hi; i++) applyStimulus(1'b1, 1'($urandom), 4'($urandom), 16'($urandom));
    for (int i = 0; i < lo; i++) applyStimulus(1'b0, 1'($urandom), 4'($urandom), 16'($urandom));
  endtask

  task automatic sendFrame(input bit fast);
    for (int k = 0; k < LINES; k++) begin
      if (fast) sendLine(4'(k), stim[k], 1'b1, 1, 1);
      else sendLine(4'(k), stim[k], 1'b1, $urandom_range(1, 3), $urandom_range(1, 3));
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom), 4'($urandom), 16'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] vec1;
    int v0;
    int e0;
    int firstErr;
    int genAddr;
    int sel;
    vec1 = 256'hffff_7fff_3fff_1fff_0fff_07ff_03ff_01ff_00ff_007f_003f_001f_000f_0007_0003_0001;

    // Reset state
    doReset(3);
    cmp("reset_valid", frameValid, 1'b0);
    cmp("reset_err", frameErr, 1'b0);
    cmp("reset_cnt", frameCnt, 8'd0);
    cmp("reset_data", frameData, 256'd0);

    // Eight frames of the staircase pixel pattern
    for (int k = 0; k < LINES; k++) stim[k] = 16'hffff >> k;
    v0 = validSeen;
    for (int f = 0; f < 8; f++) begin
      sendFrame(0);
      idleCycles(4);
      cmp("stair_data", frameData, vec1);
      cmp("stair_cnt", frameCnt, 8'(f + 1));
    end
    cmp("stair_valid_pulses", validSeen - v0, 8);

    // Skipped line aborts the frame, then a clean A5A5 frame
    e0 = errSeen;
    for (int k = 0; k < 8; k++) sendLine(4'(k), 16'h1111, 1'b1, 1, 2);
    sendLine(4'd9, 16'h2222, 1'b1, 1, 2);
    idleCycles(3);
    cmp("skip_err_pulses", errSeen - e0, 1);
    cmp("skip_data_held", frameData, vec1);
    for (int k = 0; k < LINES; k++) stim[k] = 16'hA5A5;
    sendFrame(0);
    idleCycles(4);
    cmp("a5_data", frameData, {16{16'hA5A5}});
    cmp("a5_cnt", frameCnt, 8'd9);

    // Repeated line 0 restarts the frame with the second copy of line 0
    e0 = errSeen;
    sendLine(4'd0, 16'h0F0F, 1'b1, 2, 1);
    for (int k = 1; k < 6; k++) sendLine(4'(k), 16'h1234, 1'b1, 1, 2);
    sendLine(4'd0, 16'hBEEF, 1'b1, 1, 1);
    for (int k = 1; k < LINES; k++) sendLine(4'(k), 16'h1234, 1'b1, 1, 1);
    idleCycles(4);
    cmp("restart_err_pulses", errSeen - e0, 1);
    cmp("restart_data", frameData, {16'hBEEF, {15{16'h1234}}});
    cmp("restart_cnt", frameCnt, 8'd10);

    // Stall after line 3. The error appears 65 edges after line 3 is sampled,
    // i.e. after 64 idle cycles in the receiving state.
    for (int k = 0; k < 3; k++) sendLine(4'(k), 16'h5555, 1'b1, 1, 1);
    sendLine(4'd3, 16'h5555, 1'b1, 1, 1);
    firstErr = -1;
    for (int i = 1; i <= 70; i++) begin
      idleCycles(1);
      if (frameErr === 1'b1 && firstErr < 0) firstErr = i;
    end
    cmp("timeout_cycle", firstErr, 65);
    cmp("timeout_data_held", frameData, {16'hBEEF, {15{16'h1234}}});
    cmp("timeout_cnt_held", frameCnt, 8'd10);

    // Strobes with the enable low are interleaved and must be ignored
    for (int k = 0; k < LINES; k++) begin
      stim[k] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) sendLine(4'($urandom), 16'($urandom), 1'b0, 1, 1);
      sendLine(4'(k), stim[k], 1'b1, 1, $urandom_range(1, 2));
    end
    idleCycles(4);
    cmp("noen_cnt", frameCnt, 8'd11);

    // Reset in the middle of a frame
    e0 = errSeen;
    for (int k = 0; k < 5; k++) sendLine(4'(k), 16'h7777, 1'b1, 1, 1);
    doReset(2);
    idleCycles(3);
    cmp("midreset_cnt", frameCnt, 8'd0);
    cmp("midreset_data", frameData, 256'd0);
    cmp("midreset_no_err", errSeen - e0, 0);

    // 256 back-to-back frames with one-cycle LDM_CLK phases
    v0 = validSeen;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < LINES; k++) stim[k] = 16'($urandom);
      sendFrame(1);
    end
    idleCycles(4);
    cmp("wrap_valid_pulses", validSeen - v0, 256);
    cmp("wrap_cnt", frameCnt, 8'd0);

    // Randomized traffic: mostly in-order lines with skips, disabled strobes
    // and occasional long gaps
    genAddr = 0;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 80) begin
        sendLine(4'(genAddr), 16'($urandom), 1'b1, $urandom_range(1, 3), $urandom_range(1, 3));
        genAddr = (genAddr + 1) % LINES;
      end else if (sel < 88) begin
        sendLine(4'($urandom), 16'($urandom), 1'b1, $urandom_range(1, 2), $urandom_range(1, 2));
      end else if (sel < 95) begin
        sendLine(4'($urandom), 16'($urandom), 1'b0, 1, $urandom_range(1, 2));
      end else begin
        idleCycles($urandom_range(40, 80));
      end
    end
    idleCycles(80);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
